// File: rtl/gps_pkg.sv
// gps_pkg: shared constants, state encodings and time-packing helper for the GPS RMC parser
package gps_pkg;

    localparam logic [7:0] ASC_DOLLAR = 8'h24;
    localparam logic [7:0] ASC_COMMA  = 8'h2C;
    localparam logic [7:0] ASC_A      = 8'h41;
    localparam logic [7:0] ASC_R      = 8'h52;
    localparam logic [7:0] ASC_M      = 8'h4D;
    localparam logic [7:0] ASC_C      = 8'h43;
    localparam logic [7:0] ASC_0      = 8'h30;

    typedef enum logic [2:0] {IDLE, HDR, C1, TIME, SKIP, STATUS, CHECK, COMMIT} state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // Binary hour plus BCD minute/second digits packed as hh*10000 + mm*100 + ss.
    function automatic logic [17:0] bcd2bin_hhmmss(input logic [6:0] hl, input logic [3:0] m10,
                                                   input logic [3:0] m1, input logic [3:0] s10,
                                                   input logic [3:0] s1);
        return 18'(hl) * 18'd10000 + 18'(m10) * 18'd1000 + 18'(m1) * 18'd100
             + 18'(s10) * 18'd10 + 18'(s1);
    endfunction

endpackage

// File: rtl/gps_rmc_time_parser_if.sv
// gps_rmc_time_parser_if: GPS serial input and parsed-time outputs
//   gps_rx       : UART serial line, idles high
//   shijian      : local time hhmmss as binary integer
//   shijian_stb  : one-cycle pulse when shijian updates
//   flag_shijian : time is fresh
//   frame_err    : one-cycle pulse on a stop-bit error
interface gps_rmc_time_parser_if;
    logic        gps_rx;
    logic [17:0] shijian;
    logic        shijian_stb;
    logic        flag_shijian;
    logic        frame_err;
    modport master(input gps_rx, output shijian, shijian_stb, flag_shijian, frame_err);
    modport slave(output gps_rx, input shijian, shijian_stb, flag_shijian, frame_err);
endinterface

// File: rtl/gps_uart_rx.sv
// gps_uart_rx: 8N1 UART byte receiver with input synchronizer
//   clk, rst_n : clock, asynchronous active-high reset
//   gps_rx     : serial input
//   byte_data  : received byte, valid with byte_valid
//   byte_valid : one-cycle pulse per good byte
//   frame_err  : one-cycle pulse when the stop bit reads 0 (byte dropped)
module gps_uart_rx
    import gps_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       gps_rx,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       frame_err
);
    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int CW = $clog2(BAUD_DIV);

    rx_state_t      st_q;
    logic [2:0]     rx_q;
    logic [CW-1:0]  cnt_q;
    logic [2:0]     bit_q;
    logic [7:0]     sh_q;
    logic           falling_d;

    // rx_q[1] is the synchronized line, rx_q[2] its previous value
    assign falling_d = rx_q[2] & ~rx_q[1];

    always_ff @(posedge clk or posedge rst_n)
        if (rst_n) begin
            rx_q       <= '1;
            st_q       <= RX_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            sh_q       <= '0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_q       <= {rx_q[1:0], gps_rx};
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (st_q)
                RX_IDLE:
                    if (falling_d) begin
                        st_q  <= RX_START;
                        cnt_q <= '0;
                    end
                RX_START:
                    // glitch filter: a start bit that is high again at mid-bit is abandoned
                    if (cnt_q == CW'(BAUD_DIV / 2 - 1)) begin
                        st_q  <= rx_q[1] ? RX_IDLE : RX_DATA;
                        cnt_q <= '0;
                        bit_q <= '0;
                    end else cnt_q <= cnt_q + 1'b1;
                RX_DATA:
                    if (cnt_q == CW'(BAUD_DIV - 1)) begin
                        cnt_q <= '0;
                        sh_q  <= {rx_q[1], sh_q[7:1]};
                        bit_q <= bit_q + 1'b1;
                        if (bit_q == 3'd7) st_q <= RX_STOP;
                    end else cnt_q <= cnt_q + 1'b1;
                default:
                    if (cnt_q == CW'(BAUD_DIV - 1)) begin
                        byte_valid <= rx_q[1];
                        frame_err  <= ~rx_q[1];
                        byte_data  <= sh_q;
                        st_q       <= RX_IDLE;
                    end else cnt_q <= cnt_q + 1'b1;
            endcase
        end
endmodule

// File: rtl/gps_rmc_time_parser.sv
// gps_rmc_time_parser: parses UTC time from NMEA RMC sentences and presents local hhmmss
//   clk, rst_n : clock, asynchronous active-high reset
//   bus        : gps_rx in; shijian, shijian_stb, flag_shijian, frame_err out
module gps_rmc_time_parser
    import gps_pkg::*;
#(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD      = 9600,
    parameter int TZ_OFFSET = 8,
    parameter int STALE_SEC = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    gps_rmc_time_parser_if.master bus
);
    localparam int unsigned STALE_CYC = STALE_SEC * CLK_FREQ;
    localparam int SW = $clog2(STALE_CYC + 1);

    logic [7:0]       byte_data;
    logic             byte_valid;
    logic             frame_err;
    state_t           st_q;
    logic [2:0]       idx_q;
    logic [5:0][3:0]  dig_q;
    logic [17:0]      shijian_q;
    logic             stb_q;
    logic             flag_q;
    logic [SW-1:0]    stale_q;
    logic [6:0]       hh_d, mm_d, ss_d, hs_d, hl_d;
    logic             range_ok_d, commit_d, is_digit_d, is_letter_d, hdr_ok_d;

    gps_uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .gps_rx    (bus.gps_rx),
        .byte_data (byte_data),
        .byte_valid(byte_valid),
        .frame_err (frame_err)
    );

    always_comb begin
        hh_d        = 7'(dig_q[0]) * 7'd10 + 7'(dig_q[1]);
        mm_d        = 7'(dig_q[2]) * 7'd10 + 7'(dig_q[3]);
        ss_d        = 7'(dig_q[4]) * 7'd10 + 7'(dig_q[5]);
        hs_d        = hh_d + 7'(TZ_OFFSET);
        hl_d        = (hs_d >= 7'd24) ? hs_d - 7'd24 : hs_d;
        range_ok_d  = (hh_d <= 7'd23) && (mm_d <= 7'd59) && (ss_d <= 7'd59);
        commit_d    = (st_q == CHECK) && range_ok_d;
        is_digit_d  = (byte_data >= ASC_0) && (byte_data <= ASC_0 + 8'd9);
        is_letter_d = ((byte_data >= 8'h41) && (byte_data <= 8'h5A)) ||
                      ((byte_data >= 8'h61) && (byte_data <= 8'h7A));
        // talker id (first two chars) is any letter; sentence id must be RMC
        hdr_ok_d    = (idx_q < 3'd2) ? is_letter_d :
                      byte_data == ((idx_q == 3'd2) ? ASC_R : (idx_q == 3'd3) ? ASC_M : ASC_C);
    end

    // Outputs are registered on leaving CHECK so shijian_stb is high exactly during COMMIT,
    // two clocks after the status byte's byte_valid.
    always_ff @(posedge clk or posedge rst_n)
        if (rst_n) begin
            st_q      <= IDLE;
            idx_q     <= '0;
            dig_q     <= '0;
            shijian_q <= '0;
            stb_q     <= 1'b0;
        end else begin
            stb_q <= commit_d;
            if (commit_d) shijian_q <= bcd2bin_hhmmss(hl_d, dig_q[2], dig_q[3], dig_q[4], dig_q[5]);
            if (st_q == CHECK) st_q <= range_ok_d ? COMMIT : IDLE;
            else if (st_q == COMMIT) st_q <= IDLE;
            else if (byte_valid) begin
                if (byte_data == ASC_DOLLAR) begin
                    st_q  <= HDR;
                    idx_q <= '0;
                end else
                    case (st_q)
                        HDR: begin
                            st_q  <= !hdr_ok_d ? IDLE : (idx_q == 3'd4) ? C1 : HDR;
                            idx_q <= idx_q + 1'b1;
                        end
                        C1: begin
                            st_q  <= (byte_data == ASC_COMMA) ? TIME : IDLE;
                            idx_q <= '0;
                        end
                        TIME: begin
                            dig_q[idx_q] <= byte_data[3:0];
                            idx_q        <= idx_q + 1'b1;
                            st_q         <= !is_digit_d ? IDLE : (idx_q == 3'd5) ? SKIP : TIME;
                        end
                        SKIP:   if (byte_data == ASC_COMMA) st_q <= STATUS;
                        STATUS: st_q <= (byte_data == ASC_A) ? CHECK : IDLE;
                        default: ;
                    endcase
            end
        end

    // Freshness timer: saturating cycle count since the last commit
    always_ff @(posedge clk or posedge rst_n)
        if (rst_n) begin
            stale_q <= '0;
            flag_q  <= 1'b0;
        end else begin
            stale_q <= commit_d ? '0 : (stale_q == SW'(STALE_CYC)) ? stale_q : stale_q + 1'b1;
            flag_q  <= commit_d | (flag_q & (stale_q != SW'(STALE_CYC)));
        end

    assign bus.shijian      = shijian_q;
    assign bus.shijian_stb  = stb_q;
    assign bus.flag_shijian = flag_q;
    assign bus.frame_err    = frame_err;
endmodule
